// File: rtl/vga_timing_if.sv
// Raster timing bundle between the VGA timing generator and the output stage.
// frame_count is present only when VGA_FRAME_COUNT_EN is defined.
interface vga_timing_if;
    logic        en;
    logic [10:0] drawX;
    logic [10:0] drawY;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        frame_clk;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count;

    modport master (input en, output drawX, drawY, hs, vs, blank, frame_clk, frame_count);
    modport slave  (output en, input drawX, drawY, hs, vs, blank, frame_clk, frame_count);
`else
    modport master (input en, output drawX, drawY, hs, vs, blank, frame_clk);
    modport slave  (output en, input drawX, drawY, hs, vs, blank, frame_clk);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: registered coordinates, syncs, blank and frame tick.
// Optional VGA_FRAME_COUNT_EN adds a 16-bit frame counter output.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic         pixel_clk,
    input  logic         rst_n,
    vga_timing_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [10:0] r_h_cnt, r_v_cnt;
    logic [10:0] r_drawX, r_drawY;
    logic        r_hs, r_vs, r_blank, r_frame_clk;
    logic        w_h_last, w_v_last;
    logic        w_blank, w_hs, w_vs, w_frame_tick;

    assign w_h_last = (r_h_cnt == 11'(H_TOTAL - 1));
    assign w_v_last = (r_v_cnt == 11'(V_TOTAL - 1));

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (bus.en) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? 11'd0 : r_v_cnt + 11'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 11'd1;
            end
        end
    end

    assign w_blank      = (r_h_cnt >= 11'(H_ACTIVE)) || (r_v_cnt >= 11'(V_ACTIVE));
    assign w_hs         = !((r_h_cnt >= 11'(H_ACTIVE + H_FP)) &&
                            (r_h_cnt <  11'(H_ACTIVE + H_FP + H_SYNC)));
    assign w_vs         = !((r_v_cnt >= 11'(V_ACTIVE + V_FP)) &&
                            (r_v_cnt <  11'(V_ACTIVE + V_FP + V_SYNC)));
    assign w_frame_tick = (r_h_cnt == 11'd0) && (r_v_cnt == 11'(V_ACTIVE));

    // frame_clk drops while paused so a held tick cannot be seen twice
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drawX     <= '0;
            r_drawY     <= '0;
            r_hs        <= 1'b1;
            r_vs        <= 1'b1;
            r_blank     <= 1'b1;
            r_frame_clk <= 1'b0;
        end else if (bus.en) begin
            r_drawX     <= r_h_cnt;
            r_drawY     <= r_v_cnt;
            r_hs        <= w_hs;
            r_vs        <= w_vs;
            r_blank     <= w_blank;
            r_frame_clk <= w_frame_tick;
        end else begin
            r_frame_clk <= 1'b0;
        end
    end

    assign bus.drawX     = r_drawX;
    assign bus.drawY     = r_drawY;
    assign bus.hs        = r_hs;
    assign bus.vs        = r_vs;
    assign bus.blank     = r_blank;
    assign bus.frame_clk = r_frame_clk;

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n)
            r_frame_count <= '0;
        else if (bus.en && w_frame_tick)
            r_frame_count <= r_frame_count + 16'd1;
    end

    assign bus.frame_count = r_frame_count;
`endif
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the pixel clock: pixel coordinates, horizontal/vertical sync and blanking.
- Sits directly upstream of the graphics output stage. That stage consumes drawX/drawY for pixel lookup and delays hs/vs/blank by 2 cycles to match memory latency.
- Also produces a once-per-frame tick for game/update logic.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
pixel_clk  in  1  pixel clock (25.175 MHz nominal); all logic on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  count enable; when low, raster position and all outputs hold
drawX  out  11  current pixel column, 0..H_TOTAL-1
drawY  out  11  current line, 0..V_TOTAL-1
hs  out  1  horizontal sync, active-low
vs  out  1  vertical sync, active-low
blank  out  1  1 outside the visible region
frame_clk  out  1  one-cycle pulse at the start of vertical blanking

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Internal counters h_cnt and v_cnt are 11 bits each.
- Counting, when en=1 on each edge:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0.
  - On the h_cnt wrap, v_cnt increments; at V_TOTAL-1 it wraps to 0.
  - The h wrap and v wrap in the same cycle (800x525 corner) take h_cnt and v_cnt both to 0.
- All outputs are registered decodes of the counter values before the edge. Outputs therefore describe position (h_cnt, v_cnt) one cycle after the counter held it; the outputs are mutually aligned.
- Output decode:
  - drawX = h_cnt; drawY = v_cnt.
  - blank = (h_cnt >= H_ACTIVE) or (v_cnt >= V_ACTIVE).
  - hs = 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vs = 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
  - frame_clk = 1 iff h_cnt == 0 and v_cnt == V_ACTIVE (480); exactly one pulse per frame.
- Reset (async assert, any time including mid-frame):
  - h_cnt = 0, v_cnt = 0.
  - Outputs: drawX = 0, drawY = 0, hs = 1, vs = 1, blank = 1, frame_clk = 0.
- Reset release: the first enabled edge outputs drawX=0, drawY=0, blank=0, hs=1, vs=1. The counters advance to h_cnt=1.
- en=0: counters and every output register hold their values, with one exception: frame_clk is forced to 0 so that no pulse is repeated. Resuming continues seamlessly from the held position.
- No arithmetic overflow: the counters never exceed TOTAL-1.
- Parameters must satisfy H_TOTAL, V_TOTAL <= 2048.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- When defined:
  - Adds output frame_count, 16 bits, reset value 0.
  - frame_count increments by 1 on the same edge that registers frame_clk=1.
  - frame_count wraps 65535 -> 0.
  - frame_count holds while en=0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then en=1 for 800 cycles:
  - Output cycle k shows drawX=k.
  - blank=0 for k 0..639 and blank=1 for k 640..799.
  - hs=0 exactly for drawX 656..751 (96 cycles).
  - Next cycle shows drawX=0, drawY=1.
- Run one full frame (420000 cycles):
  - vs=0 exactly during drawY 490..491 (1600 cycles).
  - frame_clk pulses once, at drawX=0, drawY=480.
  - Wrap from drawX=799, drawY=524 gives drawX=0, drawY=0.
- en low for 50 cycles at drawX=300, drawY=100:
  - Outputs hold at 300/100.
  - After re-enable, the next outputs are 301/100.
- en dropped on the frame_clk cycle:
  - frame_clk reads 0 while held.
  - Exactly 1 pulse is observed across that frame.
- Assert rst_n=0 asynchronously (off clock edge) at drawX=700, drawY=491:
  - Outputs immediately become 0/0, hs=1, vs=1, blank=1, frame_clk=0.
  - On release, counting restarts from 0/0.
- With VGA_FRAME_COUNT_EN, run 3 frames: frame_count reads 0, then 1, 2, 3, each step coincident with a frame_clk pulse.
- With VGA_FRAME_COUNT_EN, preload frame_count=65535 via force: the next pulse gives frame_count=0.
